// File: rtl/mem_arb_pkg.sv
// Shared types for the IFU/LSU memory-port arbiter: FSM states, owner encoding,
// the latched request bundle and the conflict-resolution helper.
package mem_arb_pkg;

    localparam int ARB_ADDR_MAX = 64;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_DONE = 2'd3
    } arb_state_t;

    typedef enum logic {
        OWN_IFU = 1'b0,
        OWN_LSU = 1'b1
    } owner_t;

    typedef struct packed {
        logic [ARB_ADDR_MAX-1:0] addr;
        logic                    wen;
        logic [63:0]             wdata;
        logic [7:0]              wmask;
    } req_bundle_t;

    // On a conflict the requester that did not own the previous transaction wins.
    function automatic owner_t pick_winner(input logic ifu_ask, input logic lsu_ask,
                                           input owner_t last);
        if (ifu_ask && lsu_ask) begin
            return (last == OWN_IFU) ? OWN_LSU : OWN_IFU;
        end
        return lsu_ask ? OWN_LSU : OWN_IFU;
    endfunction

endpackage

// File: rtl/mem_arb_watchdog.sv
// Response watchdog: counts cycles while enabled and flags the last allowed cycle.
// TIMEOUT of 0 disables it entirely.
module mem_arb_watchdog #(
    parameter int TIMEOUT = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);
    localparam logic [CW-1:0] SAT  = CW'(TIMEOUT);

    logic [CW-1:0] r_cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt <= '0;
        end else if (clear) begin
            r_cnt <= '0;
        end else if (enable && (r_cnt != SAT)) begin
            r_cnt <= r_cnt + CW'(1);
        end
    end

    assign expired = (TIMEOUT != 0) && enable && (r_cnt == LAST);

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between instruction fetch and load/store, one transaction
// in flight, with alternating conflict priority, fetch flush and a response watchdog.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W  = 64,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ifu_req,
    input  logic [ADDR_W-1:0] ifu_addr,
    input  logic              ifu_flush,
    output logic              ifu_gnt,
    output logic              ifu_rvalid,
    output logic [31:0]       ifu_rdata,
    input  logic              lsu_req,
    input  logic              lsu_wen,
    input  logic [ADDR_W-1:0] lsu_addr,
    input  logic [63:0]       lsu_wdata,
    input  logic [7:0]        lsu_wmask,
    output logic              lsu_gnt,
    output logic              lsu_finish,
    output logic [63:0]       lsu_rdata,
    output logic              mem_req_valid,
    input  logic              mem_req_ready,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_wen,
    output logic [63:0]       mem_wdata,
    output logic [7:0]        mem_wmask,
    input  logic              mem_resp_valid,
    input  logic [63:0]       mem_resp_data,
    output logic              timeout_err
);

    arb_state_t  r_state, w_state_next;
    owner_t      r_owner, r_last_owner, w_winner;
    req_bundle_t r_req;
    logic        r_drop;
    logic        r_timeout_err;
    logic [63:0] r_lsu_rdata;
    logic [31:0] r_ifu_rdata;

    logic        w_ifu_ask, w_lsu_ask, w_grant;
    logic        w_expired, w_capture;
    logic [63:0] w_cap_data;

    assign w_ifu_ask  = ifu_req & ~ifu_flush;
    assign w_lsu_ask  = lsu_req;
    assign w_winner   = pick_winner(w_ifu_ask, w_lsu_ask, r_last_owner);
    assign w_capture  = (r_state == ST_WAIT) && (mem_resp_valid || w_expired);
    assign w_cap_data = mem_resp_valid ? mem_resp_data : 64'd0;

    mem_arb_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_watchdog (
        .clk     (clk),
        .rst     (rst),
        .clear   ((r_state == ST_REQ) && mem_req_ready),
        .enable  (r_state == ST_WAIT),
        .expired (w_expired)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Grants are gated by reset so nothing pulses while the block is held in reset.
    always_comb begin
        w_state_next  = r_state;
        w_grant       = 1'b0;
        ifu_gnt       = 1'b0;
        lsu_gnt       = 1'b0;
        mem_req_valid = 1'b0;
        lsu_finish    = 1'b0;
        ifu_rvalid    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (rst && (w_ifu_ask || w_lsu_ask)) begin
                    w_grant      = 1'b1;
                    ifu_gnt      = (w_winner == OWN_IFU);
                    lsu_gnt      = (w_winner == OWN_LSU);
                    w_state_next = ST_REQ;
                end
            end
            ST_REQ: begin
                mem_req_valid = 1'b1;
                if (mem_req_ready) begin
                    w_state_next = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (mem_resp_valid || w_expired) begin
                    w_state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                lsu_finish   = (r_owner == OWN_LSU);
                ifu_rvalid   = (r_owner == OWN_IFU) && !r_drop;
                w_state_next = ST_IDLE;
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_owner       <= OWN_IFU;
            r_last_owner  <= OWN_IFU;
            r_req         <= '0;
            r_drop        <= 1'b0;
            r_timeout_err <= 1'b0;
            r_lsu_rdata   <= '0;
            r_ifu_rdata   <= '0;
        end else begin
            r_timeout_err <= 1'b0;
            if (w_grant) begin
                r_owner      <= w_winner;
                r_last_owner <= w_winner;
                if (w_winner == OWN_LSU) begin
                    r_req <= '{addr: ARB_ADDR_MAX'(lsu_addr), wen: lsu_wen,
                               wdata: lsu_wdata, wmask: lsu_wmask};
                end else begin
                    r_req <= '{addr: ARB_ADDR_MAX'(ifu_addr), wen: 1'b0,
                               wdata: 64'd0, wmask: 8'd0};
                end
            end
            if (w_capture) begin
                r_timeout_err <= !mem_resp_valid;
                if (r_owner == OWN_LSU) begin
                    r_lsu_rdata <= w_cap_data;
                end else if (!r_drop && !ifu_flush) begin
                    // A discarded fetch is not a completion, so the old word is kept.
                    r_ifu_rdata <= r_req.addr[2] ? w_cap_data[63:32] : w_cap_data[31:0];
                end
            end
            if (r_state == ST_DONE) begin
                r_drop <= 1'b0;
            end else if (ifu_flush && (r_owner == OWN_IFU) && (r_state != ST_IDLE)) begin
                r_drop <= 1'b1;
            end
        end
    end

    assign mem_addr    = r_req.addr[ADDR_W-1:0];
    assign mem_wen     = r_req.wen;
    assign mem_wdata   = r_req.wdata;
    assign mem_wmask   = r_req.wmask;
    assign lsu_rdata   = r_lsu_rdata;
    assign ifu_rdata   = r_ifu_rdata;
    assign timeout_err = r_timeout_err;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed vector table, hand-written
// reset/flush sequences and randomized transactions against a transaction-level model.
module tb_mem_port_arbiter;

    localparam int AW  = 64;
    localparam int TMO = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          ifu_req = 1'b0, ifu_flush = 1'b0, lsu_req = 1'b0, lsu_wen = 1'b0;
    logic          mem_req_ready = 1'b0, mem_resp_valid = 1'b0;
    logic [AW-1:0] ifu_addr = '0, lsu_addr = '0;
    logic [63:0]   lsu_wdata = '0, mem_resp_data = '0;
    logic [7:0]    lsu_wmask = '0;

    logic          ifu_gnt, ifu_rvalid, lsu_gnt, lsu_finish, mem_req_valid, mem_wen, timeout_err;
    logic [31:0]   ifu_rdata;
    logic [63:0]   lsu_rdata, mem_wdata;
    logic [AW-1:0] mem_addr;
    logic [7:0]    mem_wmask;

    int total = 0;
    int bad   = 0;

    // transaction-level reference state
    logic        last_lsu = 1'b0;
    logic [63:0] m_lsu = '0;
    logic [31:0] m_ifu = '0;

    always #5 clk = ~clk;

    mem_port_arbiter #(.ADDR_W(AW), .TIMEOUT(TMO)) dut (
        .clk            (clk),
        .rst            (rst),
        .ifu_req        (ifu_req),
        .ifu_addr       (ifu_addr),
        .ifu_flush      (ifu_flush),
        .ifu_gnt        (ifu_gnt),
        .ifu_rvalid     (ifu_rvalid),
        .ifu_rdata      (ifu_rdata),
        .lsu_req        (lsu_req),
        .lsu_wen        (lsu_wen),
        .lsu_addr       (lsu_addr),
        .lsu_wdata      (lsu_wdata),
        .lsu_wmask      (lsu_wmask),
        .lsu_gnt        (lsu_gnt),
        .lsu_finish     (lsu_finish),
        .lsu_rdata      (lsu_rdata),
        .mem_req_valid  (mem_req_valid),
        .mem_req_ready  (mem_req_ready),
        .mem_addr       (mem_addr),
        .mem_wen        (mem_wen),
        .mem_wdata      (mem_wdata),
        .mem_wmask      (mem_wmask),
        .mem_resp_valid (mem_resp_valid),
        .mem_resp_data  (mem_resp_data),
        .timeout_err    (timeout_err)
    );

    typedef struct {
        logic        ireq, lreq, wen;
        logic [63:0] iaddr, laddr, wdata, rdata;
        logic [7:0]  wmask;
        int          rdly, rsp, flush_at;
        logic        exp_lsu;
        logic [63:0] exp_lrd;
        logic [31:0] exp_ird;
        logic        exp_rv, exp_tmo;
    } vec_t;

    vec_t tbl [10];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic ireq, input logic lreq, input logic wen,
                                input logic [63:0] iaddr, input logic [63:0] laddr,
                                input logic [63:0] wdata, input logic [7:0] wmask,
                                input logic [63:0] rdata, input int rdly, input int rsp,
                                input int fl, input logic exp_lsu, input logic [63:0] exp_lrd,
                                input logic [31:0] exp_ird, input logic exp_rv,
                                input logic exp_tmo);
        vec_t v;
        v.ireq = ireq; v.lreq = lreq; v.wen = wen;
        v.iaddr = iaddr; v.laddr = laddr; v.wdata = wdata; v.wmask = wmask;
        v.rdata = rdata; v.rdly = rdly; v.rsp = rsp; v.flush_at = fl;
        v.exp_lsu = exp_lsu; v.exp_lrd = exp_lrd; v.exp_ird = exp_ird;
        v.exp_rv = exp_rv; v.exp_tmo = exp_tmo;
        return v;
    endfunction

    task automatic chk_reset_outs(input string tag);
        chk({tag, " gnts"}, {62'd0, ifu_gnt, lsu_gnt}, 64'd0);
        chk({tag, " pulses"}, {61'd0, lsu_finish, ifu_rvalid, timeout_err}, 64'd0);
        chk({tag, " req_valid"}, {63'd0, mem_req_valid}, 64'd0);
        chk({tag, " wen_wmask"}, {55'd0, mem_wen, mem_wmask}, 64'd0);
        chk({tag, " mem_addr"}, mem_addr, 64'd0);
        chk({tag, " mem_wdata"}, mem_wdata, 64'd0);
        chk({tag, " lsu_rdata"}, lsu_rdata, 64'd0);
        chk({tag, " ifu_rdata"}, {32'd0, ifu_rdata}, 64'd0);
    endtask

    // One transaction: grant cycle, REQ for rdly+1 cycles, WAIT until response or
    // watchdog, then DONE. Junk responses are driven outside WAIT and must be ignored.
    task automatic do_txn(input vec_t v, input string tag);
        int   nw, ndone;
        logic stray;
        nw    = (v.rsp < TMO) ? v.rsp + 1 : TMO;
        ndone = v.rdly + 2 + nw;
        stray = 1'b0;
        @(posedge clk); #1;
        ifu_req = v.ireq; lsu_req = v.lreq; ifu_addr = v.iaddr; lsu_addr = v.laddr;
        lsu_wen = v.wen; lsu_wdata = v.wdata; lsu_wmask = v.wmask;
        ifu_flush = 1'b0; mem_req_ready = 1'b0; mem_resp_valid = 1'b0;
        #1;
        chk({tag, " gnt"}, {62'd0, ifu_gnt, lsu_gnt}, v.exp_lsu ? 64'd1 : 64'd2);
        for (int k = 1; k <= ndone; k++) begin
            @(posedge clk); #1;
            ifu_req = 1'b0; lsu_req = 1'b0;
            ifu_flush = (k == v.flush_at);
            mem_req_ready = (k == v.rdly + 1);
            if (k <= v.rdly + 1 || k == ndone) begin
                mem_resp_valid = 1'($urandom_range(0, 1));
                mem_resp_data  = {$urandom, $urandom};
            end else begin
                mem_resp_valid = ((k - v.rdly - 2) == v.rsp);
                mem_resp_data  = v.rdata;
            end
            #1;
            if (k < ndone) begin
                if (ifu_gnt || lsu_gnt || lsu_finish || ifu_rvalid || timeout_err) stray = 1'b1;
                if (mem_req_valid !== (k <= v.rdly + 1)) stray = 1'b1;
            end
            if (k == 1) begin
                chk({tag, " mem_addr"}, mem_addr, v.exp_lsu ? v.laddr : v.iaddr);
                chk({tag, " wen_wmask"}, {55'd0, mem_wen, mem_wmask},
                    v.exp_lsu ? {55'd0, v.wen, v.wmask} : 64'd0);
                if (v.exp_lsu) chk({tag, " mem_wdata"}, mem_wdata, v.wdata);
            end
        end
        chk({tag, " early_or_stray"}, {63'd0, stray}, 64'd0);
        chk({tag, " lsu_finish"}, {63'd0, lsu_finish}, {63'd0, v.exp_lsu});
        chk({tag, " ifu_rvalid"}, {63'd0, ifu_rvalid}, {63'd0, v.exp_rv});
        chk({tag, " timeout_err"}, {63'd0, timeout_err}, {63'd0, v.exp_tmo});
        chk({tag, " lsu_rdata"}, lsu_rdata, v.exp_lrd);
        chk({tag, " ifu_rdata"}, {32'd0, ifu_rdata}, {32'd0, v.exp_ird});
        $display("txn %s: owner=%s rdly=%0d rsp=%0d lsu_rdata=%h ifu_rdata=%h", tag,
                 v.exp_lsu ? "LSU" : "IFU", v.rdly, v.rsp, lsu_rdata, ifu_rdata);
        mem_resp_valid = 1'b0; mem_req_ready = 1'b0; ifu_flush = 1'b0;
        last_lsu = v.exp_lsu; m_lsu = v.exp_lrd; m_ifu = v.exp_ird;
    endtask

    initial begin
        #1000000;
        $display("FAIL bench_timeout: got still running required finished");
        $fatal(1);
    end

    initial begin
        vec_t v;
        int   nw;
        logic [63:0] got;

        // directed vectors, hand-derived from reset state (last owner IFU, rdata 0)
        tbl[0] = mk(0, 1, 0, 64'h0, 64'h8000_0010, 64'h0, 8'h00, 64'h1122_3344_5566_7788,
                    0, 0, -1, 1, 64'h1122_3344_5566_7788, 32'h0, 0, 0);
        tbl[1] = mk(1, 0, 0, 64'h8000_0004, 64'h0, 64'h0, 8'h00, 64'hAAAA_BBBB_CCCC_DDDD,
                    0, 0, -1, 0, 64'h1122_3344_5566_7788, 32'hAAAA_BBBB, 1, 0);
        tbl[2] = mk(1, 1, 1, 64'h8000_0008, 64'h8000_0100, 64'hDEAD_BEEF_00C0_FFEE, 8'hFF,
                    64'h0123_4567_89AB_CDEF, 0, 0, -1, 1, 64'h0123_4567_89AB_CDEF,
                    32'hAAAA_BBBB, 0, 0);
        tbl[3] = mk(1, 1, 0, 64'h8000_0008, 64'h8000_0180, 64'h0, 8'h00, 64'h5555_6666_7777_8888,
                    1, 0, -1, 0, 64'h0123_4567_89AB_CDEF, 32'h7777_8888, 1, 0);
        tbl[4] = mk(1, 1, 0, 64'h8000_000C, 64'h8000_0200, 64'h0, 8'h0F, 64'h0F0E_0D0C_0B0A_0908,
                    0, 2, -1, 1, 64'h0F0E_0D0C_0B0A_0908, 32'h7777_8888, 0, 0);
        tbl[5] = mk(1, 1, 0, 64'h8000_000C, 64'h8000_0200, 64'h0, 8'h0F, 64'h9999_AAAA_BBBB_CCCC,
                    0, 0, -1, 0, 64'h0F0E_0D0C_0B0A_0908, 32'h9999_AAAA, 1, 0);
        tbl[6] = mk(1, 0, 0, 64'h8000_0010, 64'h0, 64'h0, 8'h00, 64'h1234_5678_9ABC_DEF0,
                    0, 2, 3, 0, 64'h0F0E_0D0C_0B0A_0908, 32'h9999_AAAA, 0, 0);
        tbl[7] = mk(0, 1, 0, 64'h0, 64'h8000_0300, 64'h0, 8'h00, 64'hFFFF_FFFF_FFFF_FFFF,
                    1, 99, -1, 1, 64'h0, 32'h9999_AAAA, 0, 1);
        tbl[8] = mk(1, 0, 0, 64'h8000_0000, 64'h0, 64'h0, 8'h00, 64'hCAFE_F00D_8BAD_F00D,
                    2, 3, -1, 0, 64'h0, 32'h8BAD_F00D, 1, 0);
        tbl[9] = mk(0, 1, 1, 64'h0, 64'h8000_0400, 64'h0000_0000_CAFE_0000, 8'h3C,
                    64'h0000_0000_0000_0042, 0, 1, 2, 1, 64'h42, 32'h8BAD_F00D, 0, 0);

        // reset with both requesters asserting: nothing may be granted
        ifu_req = 1'b1; lsu_req = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk_reset_outs("por");
        ifu_req = 1'b0; lsu_req = 1'b0;
        @(negedge clk); rst = 1'b1;

        for (int i = 0; i < 10; i++) begin
            do_txn(tbl[i], $sformatf("vec%0d", i));
        end

        // a flushed fetch request in IDLE is ignored, and so is a stray response
        @(posedge clk); #1;
        ifu_req = 1'b1; ifu_flush = 1'b1; mem_resp_valid = 1'b1; mem_resp_data = 64'h77;
        #1;
        chk("idle_flush gnt", {62'd0, ifu_gnt, lsu_gnt}, 64'd0);
        ifu_req = 1'b0; ifu_flush = 1'b0; mem_resp_valid = 1'b0;
        $display("txn idle_flush: ifu_gnt=%0d lsu_gnt=%0d", ifu_gnt, lsu_gnt);

        // randomized transactions against the transaction-level model
        for (int i = 0; i < 40; i++) begin
            v.ireq  = 1'($urandom_range(0, 1));
            v.lreq  = v.ireq ? 1'($urandom_range(0, 1)) : 1'b1;
            v.wen   = 1'($urandom_range(0, 1));
            v.iaddr = {$urandom, $urandom};
            v.laddr = {$urandom, $urandom};
            v.wdata = {$urandom, $urandom};
            v.wmask = 8'($urandom);
            v.rdata = {$urandom, $urandom};
            v.rdly  = $urandom_range(0, 2);
            v.rsp   = $urandom_range(0, 5);
            nw      = (v.rsp < TMO) ? v.rsp + 1 : TMO;
            v.flush_at = ($urandom_range(0, 2) == 0) ? $urandom_range(1, v.rdly + 1 + nw) : -1;
            v.exp_lsu = (v.ireq && v.lreq) ? !last_lsu : v.lreq;
            got       = (v.rsp < TMO) ? v.rdata : 64'd0;
            v.exp_lrd = v.exp_lsu ? got : m_lsu;
            v.exp_ird = (!v.exp_lsu && v.flush_at < 0) ? (v.iaddr[2] ? got[63:32] : got[31:0])
                                                        : m_ifu;
            v.exp_rv  = !v.exp_lsu && (v.flush_at < 0);
            v.exp_tmo = (v.rsp >= TMO);
            do_txn(v, $sformatf("rnd%0d", i));
        end

        // abandon an LSU store mid-WAIT with an asynchronous reset
        @(posedge clk); #1;
        ifu_req = 1'b0; lsu_req = 1'b1; lsu_addr = 64'h8000_0500; lsu_wen = 1'b1;
        lsu_wdata = 64'h5A5A_5A5A_A5A5_A5A5; lsu_wmask = 8'hF0;
        #1;
        chk("abort gnt", {62'd0, ifu_gnt, lsu_gnt}, 64'd1);
        @(posedge clk); #1;
        lsu_req = 1'b0; mem_req_ready = 1'b1;
        @(posedge clk); #1;
        mem_req_ready = 1'b0;
        @(posedge clk); #1;
        ifu_req = 1'b1; lsu_req = 1'b1;
        #2;
        rst = 1'b0;
        #1;
        chk_reset_outs("mid_wait_reset");
        $display("txn mid_wait_reset: mem_req_valid=%0d lsu_rdata=%h", mem_req_valid, lsu_rdata);
        ifu_req = 1'b0; lsu_req = 1'b0;
        @(negedge clk); rst = 1'b1;
        last_lsu = 1'b0; m_lsu = '0; m_ifu = '0;

        // first conflict after reset goes to the LSU even though it owned the aborted one
        do_txn(mk(1, 1, 0, 64'h8000_0014, 64'h8000_0600, 64'h0, 8'h00, 64'h0BAD_CAFE_1234_5678,
                  0, 1, -1, 1, 64'h0BAD_CAFE_1234_5678, 32'h0, 0, 0), "post_reset");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
